// File: rtl/ddr4_dm_lane_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_dm_lane_tx_ctrl_if
// Purpose  : Mask-stream, ODT and delay-line signals between fabric, the DM
//            lane controller and the lane IOD wrapper.
// Revision : 1.0 - initial release
// ============================================================================
interface ddr4_dm_lane_tx_ctrl_if;
    logic       wr_mask_valid;
    logic [7:0] wr_mask;
    logic       wr_mask_ready;
    logic       rx_odt_req;
    logic [7:0] tx_data_0;
    logic [3:0] oe_data_0;
    logic       odt_en_0;
    logic       dl_req;
    logic       dl_load;
    logic       dl_dir;
    logic [7:0] dl_steps;
    logic       delay_line_out_of_range_0;
    logic       delay_line_move_0;
    logic       delay_line_direction_0;
    logic       delay_line_load_0;
    logic       dl_busy;
    logic       dl_done;
    logic       dl_err;
    logic [7:0] dl_steps_done;

    modport master (
        output wr_mask_valid, wr_mask, rx_odt_req,
        output dl_req, dl_load, dl_dir, dl_steps, delay_line_out_of_range_0,
        input  wr_mask_ready, tx_data_0, oe_data_0, odt_en_0,
        input  delay_line_move_0, delay_line_direction_0, delay_line_load_0,
        input  dl_busy, dl_done, dl_err, dl_steps_done
    );

    modport slave (
        input  wr_mask_valid, wr_mask, rx_odt_req,
        input  dl_req, dl_load, dl_dir, dl_steps, delay_line_out_of_range_0,
        output wr_mask_ready, tx_data_0, oe_data_0, odt_en_0,
        output delay_line_move_0, delay_line_direction_0, delay_line_load_0,
        output dl_busy, dl_done, dl_err, dl_steps_done
    );
endinterface
`default_nettype wire

// File: rtl/ddr4_dm_lane_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_dm_lane_tx_ctrl
// Purpose  : DDR4 DM lane TX driver: BL8 mask bursts to TX/OE serializer words
//            with OE preamble/postamble, plus delay-line step sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module ddr4_dm_lane_tx_ctrl #(
    parameter int unsigned PRE_CYCLES   = 2,
    parameter int unsigned POST_CYCLES  = 1,
    parameter logic [7:0]  IDLE_PATTERN = 8'h00,
    parameter int unsigned STEP_GAP     = 3
) (
    input  logic                   fab_clk,
    input  logic                   tx_sync_rst,
    ddr4_dm_lane_tx_ctrl_if.slave  bus
);

    localparam logic [2:0] c_pre_last  = 3'(PRE_CYCLES - 1);
    localparam logic [2:0] c_post_last = 3'(POST_CYCLES - 1);
    localparam logic [3:0] c_gap_last  = 4'(STEP_GAP - 1);

    // ------------------------------------------------------------------ TX --
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_PRE  = 2'd1,
        TX_DATA = 2'd2,
        TX_POST = 2'd3
    } tx_state_t;

    tx_state_t  r_tx_state, w_tx_state_nxt;
    logic [2:0] r_tx_cnt, w_tx_cnt_nxt;
    logic       r_ready, w_ready_nxt;
    logic [7:0] r_tx_data;
    logic [3:0] r_oe;
    logic       r_odt;
    logic       w_accept;

    assign w_accept = bus.wr_mask_valid & r_ready;

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        case (r_tx_state)
            TX_IDLE: begin
                if (bus.wr_mask_valid) begin
                    w_tx_state_nxt = TX_PRE;
                    w_tx_cnt_nxt   = 3'd0;
                end
            end
            TX_PRE: begin
                // A preamble that ends without a burst falls into the postamble
                if (r_tx_cnt == c_pre_last) begin
                    w_tx_cnt_nxt   = 3'd0;
                    w_tx_state_nxt = w_accept ? TX_DATA : TX_POST;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + 3'd1;
                end
            end
            TX_DATA: begin
                if (!w_accept) begin
                    w_tx_state_nxt = TX_POST;
                    w_tx_cnt_nxt   = 3'd0;
                end
            end
            TX_POST: begin
                if (w_accept) begin
                    w_tx_state_nxt = TX_DATA;
                end else if (r_tx_cnt == c_post_last) begin
                    w_tx_state_nxt = TX_IDLE;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + 3'd1;
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
        w_ready_nxt = ((w_tx_state_nxt == TX_PRE) && (w_tx_cnt_nxt == c_pre_last)) ||
                      (w_tx_state_nxt == TX_DATA) || (w_tx_state_nxt == TX_POST);
    end

    always_ff @(posedge fab_clk) begin
        if (tx_sync_rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= 3'd0;
            r_ready    <= 1'b0;
            r_tx_data  <= IDLE_PATTERN;
            r_oe       <= 4'h0;
            r_odt      <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_ready    <= w_ready_nxt;
            r_tx_data  <= w_accept ? bus.wr_mask : IDLE_PATTERN;
            r_oe       <= (w_tx_state_nxt != TX_IDLE) ? 4'hF : 4'h0;
            r_odt      <= bus.rx_odt_req & (w_tx_state_nxt == TX_IDLE);
        end
    end

    assign bus.wr_mask_ready = r_ready;
    assign bus.tx_data_0     = r_tx_data;
    assign bus.oe_data_0     = r_oe;
    assign bus.odt_en_0      = r_odt;

    // ---------------------------------------------------------- delay line --
    typedef enum logic [2:0] {
        DL_IDLE  = 3'd0,
        DL_SETUP = 3'd1,
        DL_LOADP = 3'd2,
        DL_PULSE = 3'd3,
        DL_GAP   = 3'd4,
        DL_END   = 3'd5
    } dl_state_t;

    dl_state_t  r_dl_state, w_dl_state_nxt;
    logic [3:0] r_gap_cnt, w_gap_cnt_nxt;
    logic [7:0] r_rem;
    logic       r_load_lat;
    logic       r_dir;
    logic       r_move;
    logic       r_load_pulse;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
    logic [7:0] r_steps_done;
    logic       w_dl_abort;
    logic       w_dl_start;

    assign w_dl_start = (r_dl_state == DL_IDLE) & bus.dl_req;

    always_comb begin
        w_dl_state_nxt = r_dl_state;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_dl_abort     = 1'b0;
        case (r_dl_state)
            DL_IDLE:  if (bus.dl_req) w_dl_state_nxt = DL_SETUP;
            DL_SETUP: begin
                if (r_load_lat)        w_dl_state_nxt = DL_LOADP;
                else if (r_rem == 8'd0) w_dl_state_nxt = DL_END;
                else                    w_dl_state_nxt = DL_PULSE;
            end
            DL_LOADP: w_dl_state_nxt = DL_END;
            DL_PULSE: begin
                w_dl_state_nxt = DL_GAP;
                w_gap_cnt_nxt  = 4'd0;
            end
            DL_GAP: begin
                // The IOD range flag is only trusted once the last move has settled
                if (r_gap_cnt == c_gap_last) begin
                    if (bus.delay_line_out_of_range_0) begin
                        w_dl_abort     = 1'b1;
                        w_dl_state_nxt = DL_END;
                    end else if (r_rem != 8'd0) begin
                        w_dl_state_nxt = DL_PULSE;
                    end else begin
                        w_dl_state_nxt = DL_END;
                    end
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 4'd1;
                end
            end
            DL_END:   w_dl_state_nxt = DL_IDLE;
            default:  w_dl_state_nxt = DL_IDLE;
        endcase
    end

    always_ff @(posedge fab_clk) begin
        if (tx_sync_rst) begin
            r_dl_state   <= DL_IDLE;
            r_gap_cnt    <= 4'd0;
            r_rem        <= 8'd0;
            r_load_lat   <= 1'b0;
            r_dir        <= 1'b0;
            r_move       <= 1'b0;
            r_load_pulse <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_steps_done <= 8'd0;
        end else begin
            r_dl_state <= w_dl_state_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            if (w_dl_start) begin
                r_rem        <= bus.dl_steps;
                r_load_lat   <= bus.dl_load;
                r_dir        <= bus.dl_dir;
                r_err        <= 1'b0;
                r_steps_done <= 8'd0;
            end else begin
                if (w_dl_state_nxt == DL_PULSE) begin
                    r_rem <= r_rem - 8'd1;
                    if (r_steps_done != 8'hFF) r_steps_done <= r_steps_done + 8'd1;
                end
                if (w_dl_abort) r_err <= 1'b1;
                if (w_dl_state_nxt == DL_IDLE) r_dir <= 1'b0;
            end
            r_move       <= (w_dl_state_nxt == DL_PULSE);
            r_load_pulse <= (w_dl_state_nxt == DL_LOADP);
            r_busy       <= (w_dl_state_nxt != DL_IDLE);
            r_done       <= (w_dl_state_nxt == DL_END);
        end
    end

    assign bus.delay_line_move_0      = r_move;
    assign bus.delay_line_direction_0 = r_dir;
    assign bus.delay_line_load_0      = r_load_pulse;
    assign bus.dl_busy                = r_busy;
    assign bus.dl_done                = r_done;
    assign bus.dl_err                 = r_err;
    assign bus.dl_steps_done          = r_steps_done;

endmodule
`default_nettype wire

// File: tb/tb_ddr4_dm_lane_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr4_dm_lane_tx_ctrl
// Purpose  : Self-checking bench for the DDR4 DM lane TX controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr4_dm_lane_tx_ctrl;

    localparam int         PRE  = 2;
    localparam int         POST = 1;
    localparam int         GAP  = 3;
    localparam logic [7:0] IDLE = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmp_en = 1'b0;

    ddr4_dm_lane_tx_ctrl_if bus();

    ddr4_dm_lane_tx_ctrl #(
        .PRE_CYCLES   (PRE),
        .POST_CYCLES  (POST),
        .IDLE_PATTERN (IDLE),
        .STEP_GAP     (GAP)
    ) dut (
        .fab_clk     (clk),
        .tx_sync_rst (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected outputs for the current cycle, advanced at every rising edge
    logic [7:0] e_tx;
    logic [3:0] e_oe;
    logic       e_ready, e_odt, e_open;
    int         e_age, e_quiet;
    logic       e_busy, e_move, e_ldp, e_done, e_err, e_dir_lat, e_dir, e_ld;
    logic [7:0] e_sd, e_nst;
    int         e_t, e_end;

    always @(posedge clk) begin : model
        bit acc;
        if (rst) begin
            e_tx = IDLE; e_oe = 4'h0; e_ready = 1'b0; e_odt = 1'b0; e_open = 1'b0;
            e_age = 0; e_quiet = 0;
            e_busy = 1'b0; e_move = 1'b0; e_ldp = 1'b0; e_done = 1'b0; e_err = 1'b0;
            e_dir_lat = 1'b0; e_dir = 1'b0; e_ld = 1'b0; e_sd = 8'd0; e_nst = 8'd0;
            e_t = 0; e_end = 0;
        end else begin
            // OE window: opens on VALID, preamble of PRE cycles, closes after
            // POST+1 consecutive post-preamble cycles without a transfer
            acc  = bus.wr_mask_valid && e_ready;
            e_tx = acc ? bus.wr_mask : IDLE;
            if (!e_open) begin
                if (bus.wr_mask_valid) begin
                    e_open = 1'b1; e_age = 1; e_quiet = 0;
                end
            end else if (acc) begin
                e_quiet = 0;
            end else if (e_age < PRE) begin
                e_age++;
            end else begin
                e_quiet++;
                if (e_quiet > POST) e_open = 1'b0;
            end
            e_oe    = e_open ? 4'hF : 4'h0;
            e_ready = e_open && (e_age >= PRE);
            e_odt   = bus.rx_odt_req && !e_open;

            // Delay line as a timeline relative to the request cycle
            if (!e_busy) begin
                if (bus.dl_req) begin
                    e_busy = 1'b1; e_t = 1; e_err = 1'b0; e_sd = 8'd0;
                    e_ld = bus.dl_load; e_dir_lat = bus.dl_dir; e_nst = bus.dl_steps;
                    e_end = bus.dl_load ? 3 :
                            (bus.dl_steps == 8'd0) ? 2 : int'(bus.dl_steps) * (GAP + 1) + 2;
                end
            end else begin
                if (!e_ld && e_nst != 8'd0 && e_t >= 2 && e_t < e_end &&
                    (e_t - 2) % (GAP + 1) == GAP && bus.delay_line_out_of_range_0) begin
                    e_err = 1'b1;
                    e_end = e_t + 1;
                end
                e_t++;
                if (e_t > e_end) e_busy = 1'b0;
            end
            e_move = e_busy && !e_ld && e_nst != 8'd0 && e_t >= 2 && e_t < e_end &&
                     (e_t - 2) % (GAP + 1) == 0;
            e_ldp  = e_busy && e_ld && e_t == 2;
            e_done = e_busy && e_t == e_end;
            e_dir  = e_busy ? e_dir_lat : 1'b0;
            if (e_move && e_sd != 8'hFF) e_sd++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Cumulative observations; tests compare deltas across a window
    int   mon_oe_hi = 0, mon_oe_rise = 0, mon_odt_viol = 0, mon_done = 0, mon_ldp = 0, cyc = 0;
    logic prev_oe_on = 1'b0;
    logic [7:0] tx_q[$];
    int   move_t[$];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] m);
        bus.wr_mask_valid = 1'b1;
        bus.wr_mask       = m;
        for (int i = 0; i < 20 && !bus.wr_mask_ready; i++) @(negedge clk);
        chk("send_ready", 32'(bus.wr_mask_ready), 32'd1);
        @(negedge clk);
        bus.wr_mask_valid = 1'b0;
    endtask

    task automatic wait_tx_idle();
        for (int i = 0; i < 50 && bus.oe_data_0 != 4'h0; i++) @(negedge clk);
        chk("tx_back_idle", 32'(bus.oe_data_0), 32'd0);
        tick(2);
    endtask

    task automatic dl_start(input logic ld, input logic dir, input logic [7:0] steps);
        bus.dl_req = 1'b1; bus.dl_load = ld; bus.dl_dir = dir; bus.dl_steps = steps;
        tick(1);
        bus.dl_req = 1'b0; bus.dl_load = 1'b0;
    endtask

    task automatic wait_dl_done();
        for (int i = 0; i < 200 && !bus.dl_done; i++) @(negedge clk);
        chk("dl_done_seen", 32'(bus.dl_done), 32'd1);
        tick(2);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int b_oe, b_rise, b_tq, b_mv, b_done, b_ldp, k;
        bus.wr_mask_valid = 1'b0; bus.wr_mask = 8'h00; bus.rx_odt_req = 1'b0;
        bus.dl_req = 1'b0; bus.dl_load = 1'b0; bus.dl_dir = 1'b0; bus.dl_steps = 8'd0;
        bus.delay_line_out_of_range_0 = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (cmp_en) begin
                    cyc++;
                    chk("tx_data_0",     32'(bus.tx_data_0),              32'(e_tx));
                    chk("oe_data_0",     32'(bus.oe_data_0),              32'(e_oe));
                    chk("wr_mask_ready", 32'(bus.wr_mask_ready),          32'(e_ready));
                    chk("odt_en_0",      32'(bus.odt_en_0),               32'(e_odt));
                    chk("dl_move",       32'(bus.delay_line_move_0),      32'(e_move));
                    chk("dl_load",       32'(bus.delay_line_load_0),      32'(e_ldp));
                    chk("dl_direction",  32'(bus.delay_line_direction_0), 32'(e_dir));
                    chk("dl_busy",       32'(bus.dl_busy),                32'(e_busy));
                    chk("dl_done",       32'(bus.dl_done),                32'(e_done));
                    chk("dl_err",        32'(bus.dl_err),                 32'(e_err));
                    chk("dl_steps_done", 32'(bus.dl_steps_done),          32'(e_sd));
                    if (bus.oe_data_0 != 4'h0) mon_oe_hi++;
                    if (bus.oe_data_0 != 4'h0 && !prev_oe_on) mon_oe_rise++;
                    prev_oe_on = (bus.oe_data_0 != 4'h0);
                    if (bus.oe_data_0 != 4'h0 && bus.odt_en_0) mon_odt_viol++;
                    if (bus.tx_data_0 != IDLE) tx_q.push_back(bus.tx_data_0);
                    if (bus.delay_line_move_0) move_t.push_back(cyc);
                    if (bus.dl_done) mon_done++;
                    if (bus.delay_line_load_0) mon_ldp++;
                end
            end
        join_none

        @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_tx_data", 32'(bus.tx_data_0), 32'h00);
        chk("reset_oe",      32'(bus.oe_data_0), 32'h0);
        chk("reset_busy",    32'(bus.dl_busy),   32'h0);
        tick(2);
        rst = 1'b0;

        // Single burst with termination requested throughout
        bus.rx_odt_req = 1'b1;
        tick(2);
        chk("odt_idle", 32'(bus.odt_en_0), 32'd1);
        b_oe = mon_oe_hi; b_rise = mon_oe_rise; b_tq = tx_q.size();
        send(8'hA5);
        wait_tx_idle();
        chk("single_oe_cycles", 32'(mon_oe_hi - b_oe), 32'd4);
        chk("single_preambles", 32'(mon_oe_rise - b_rise), 32'd1);
        chk("single_tx_count",  32'(tx_q.size() - b_tq), 32'd1);
        if (tx_q.size() > b_tq) chk("single_tx_value", 32'(tx_q[b_tq]), 32'hA5);
        chk("odt_viol", 32'(mon_odt_viol), 32'd0);
        chk("odt_after_idle", 32'(bus.odt_en_0), 32'd1);

        // Four back-to-back bursts
        b_oe = mon_oe_hi; b_rise = mon_oe_rise; b_tq = tx_q.size();
        for (int i = 1; i <= 4; i++) send(8'(i));
        wait_tx_idle();
        chk("b2b_oe_cycles", 32'(mon_oe_hi - b_oe), 32'd7);
        chk("b2b_preambles", 32'(mon_oe_rise - b_rise), 32'd1);
        chk("b2b_tx_count",  32'(tx_q.size() - b_tq), 32'd4);
        for (int i = 0; i < 4; i++)
            if (tx_q.size() > b_tq + i) chk("b2b_tx_value", 32'(tx_q[b_tq + i]), 32'(i + 1));

        // Burst, one idle cycle, burst: rejoins through the postamble
        b_oe = mon_oe_hi; b_rise = mon_oe_rise; b_tq = tx_q.size();
        send(8'h11);
        tick(1);
        send(8'h22);
        wait_tx_idle();
        chk("gap_oe_cycles", 32'(mon_oe_hi - b_oe), 32'd6);
        chk("gap_preambles", 32'(mon_oe_rise - b_rise), 32'd1);
        chk("gap_tx_count",  32'(tx_q.size() - b_tq), 32'd2);
        if (tx_q.size() > b_tq + 1) chk("gap_tx_second", 32'(tx_q[b_tq + 1]), 32'h22);
        chk("odt_viol_total", 32'(mon_odt_viol), 32'd0);

        // Five steps up
        b_mv = move_t.size(); b_done = mon_done;
        dl_start(1'b0, 1'b1, 8'd5);
        wait_dl_done();
        chk("step5_moves", 32'(move_t.size() - b_mv), 32'd5);
        for (int i = b_mv + 1; i < move_t.size(); i++)
            chk("step5_spacing", 32'(move_t[i] - move_t[i - 1]), 32'd4);
        chk("step5_done_cnt", 32'(mon_done - b_done), 32'd1);
        chk("step5_steps_done", 32'(bus.dl_steps_done), 32'd5);
        chk("step5_err", 32'(bus.dl_err), 32'd0);
        chk("step5_busy_after", 32'(bus.dl_busy), 32'd0);

        // Ten steps down, out of range after the third move
        b_mv = move_t.size();
        dl_start(1'b0, 1'b0, 8'd10);
        k = 0;
        for (int i = 0; i < 100 && k < 3; i++) begin
            @(negedge clk);
            if (bus.delay_line_move_0) k++;
        end
        chk("oor_third_move_seen", 32'(k), 32'd3);
        bus.delay_line_out_of_range_0 = 1'b1;
        wait_dl_done();
        bus.delay_line_out_of_range_0 = 1'b0;
        chk("oor_moves", 32'(move_t.size() - b_mv), 32'd3);
        chk("oor_steps_done", 32'(bus.dl_steps_done), 32'd3);
        chk("oor_err", 32'(bus.dl_err), 32'd1);
        tick(3);
        chk("oor_err_sticky", 32'(bus.dl_err), 32'd1);

        // Load sequence clears the error and issues no moves
        b_mv = move_t.size(); b_ldp = mon_ldp;
        dl_start(1'b1, 1'b1, 8'd7);
        wait_dl_done();
        chk("load_pulses", 32'(mon_ldp - b_ldp), 32'd1);
        chk("load_moves", 32'(move_t.size() - b_mv), 32'd0);
        chk("load_err_cleared", 32'(bus.dl_err), 32'd0);

        // Zero steps: immediate completion
        b_mv = move_t.size(); b_done = mon_done;
        dl_start(1'b0, 1'b1, 8'd0);
        wait_dl_done();
        chk("zero_moves", 32'(move_t.size() - b_mv), 32'd0);
        chk("zero_done_cnt", 32'(mon_done - b_done), 32'd1);

        // Reset in the middle of a burst stream and a step sequence
        bus.wr_mask_valid = 1'b1; bus.wr_mask = 8'h5A;
        dl_start(1'b0, 1'b1, 8'd10);
        k = 0;
        for (int i = 0; i < 100 && k < 2; i++) begin
            @(negedge clk);
            if (bus.delay_line_move_0) k++;
        end
        chk("mid_moves_seen", 32'(k), 32'd2);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_move",  32'(bus.delay_line_move_0), 32'd0);
        chk("mid_rst_busy",  32'(bus.dl_busy),           32'd0);
        chk("mid_rst_oe",    32'(bus.oe_data_0),         32'd0);
        chk("mid_rst_tx",    32'(bus.tx_data_0),         32'(IDLE));
        chk("mid_rst_ready", 32'(bus.wr_mask_ready),     32'd0);
        bus.wr_mask_valid = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
